// File: rtl/of_hazard_ctrl.sv
// Scoreboard issue controller between operand fetch and execute: RAW/WAW/multi-cycle-unit
// hazard detection, per-register busy tracking and a saturating stall counter.
// Optional writeback bypass: define OF_HAZARD_FWD_EN to enable it and add the fwd1/fwd2 outputs.
module of_hazard_ctrl #(
    parameter int NREG    = 16,
    parameter int RW      = 4,
    parameter int MDU_LAT = 4,
    parameter int SCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              of_valid,
    input  logic [RW-1:0]     of_rs1,
    input  logic [RW-1:0]     of_rs2,
    input  logic              of_use1,
    input  logic              of_use2,
    input  logic [RW-1:0]     of_rd,
    input  logic              of_wr,
    input  logic              of_multi,
    input  logic              ex_ready,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [RW-1:0]     wb_rd,
    output logic              issue,
    output logic              stall,
    output logic [NREG-1:0]   busy,
    output logic              mdu_busy,
    output logic [SCNT_W-1:0] stall_cycles
`ifdef OF_HAZARD_FWD_EN
    ,
    output logic              fwd1,
    output logic              fwd2
`endif
);

    logic [3:0]      mdu_cnt;
    logic [NREG-1:0] busy_nxt;
    logic            raw1;
    logic            raw2;
    logic            waw;
    logic            hazard;

`ifdef OF_HAZARD_FWD_EN
    logic wb_hit1;
    logic wb_hit2;
    logic wb_hitd;

    // A writeback landing this cycle resolves the dependency through the bypass path.
    assign wb_hit1 = wb_valid & (wb_rd == of_rs1);
    assign wb_hit2 = wb_valid & (wb_rd == of_rs2);
    assign wb_hitd = wb_valid & (wb_rd == of_rd);
    assign raw1    = of_use1 & busy[of_rs1] & ~wb_hit1;
    assign raw2    = of_use2 & busy[of_rs2] & ~wb_hit2;
    assign waw     = of_wr & busy[of_rd] & ~wb_hitd;
    assign fwd1    = of_valid & of_use1 & busy[of_rs1] & wb_hit1;
    assign fwd2    = of_valid & of_use2 & busy[of_rs2] & wb_hit2;
`else
    assign raw1 = of_use1 & busy[of_rs1];
    assign raw2 = of_use2 & busy[of_rs2];
    assign waw  = of_wr & busy[of_rd];
`endif

    assign hazard   = of_valid & (raw1 | raw2 | waw | (of_multi & (mdu_cnt != 4'd0)));
    assign issue    = of_valid & ~flush & ~hazard & ex_ready;
    assign stall    = of_valid & ~flush & (hazard | ~ex_ready);
    assign mdu_busy = (mdu_cnt != 4'd0);

    // Clear first so a same-cycle set on the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (issue && of_wr) begin
            busy_nxt[of_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= '0;
            mdu_cnt      <= 4'd0;
            stall_cycles <= '0;
        end else begin
            busy <= busy_nxt;
            if (issue && of_multi) begin
                mdu_cnt <= 4'(MDU_LAT);
            end else if (mdu_cnt != 4'd0) begin
                mdu_cnt <= mdu_cnt - 4'd1;
            end
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_of_hazard_ctrl.sv
// Directed testbench for of_hazard_ctrl; expectations also cover OF_HAZARD_FWD_EN builds.
module tb_of_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        of_valid;
    logic [3:0]  of_rs1;
    logic [3:0]  of_rs2;
    logic        of_use1;
    logic        of_use2;
    logic [3:0]  of_rd;
    logic        of_wr;
    logic        of_multi;
    logic        ex_ready;
    logic        flush;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        issue;
    logic        stall;
    logic [15:0] busy;
    logic        mdu_busy;
    logic [15:0] stall_cycles;
`ifdef OF_HAZARD_FWD_EN
    logic        fwd1;
    logic        fwd2;
`endif

    int checks;
    int errors;

    of_hazard_ctrl #(.NREG(16), .RW(4), .MDU_LAT(4), .SCNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
        .of_use1(of_use1), .of_use2(of_use2), .of_rd(of_rd), .of_wr(of_wr),
        .of_multi(of_multi), .ex_ready(ex_ready), .flush(flush), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .issue(issue), .stall(stall), .busy(busy), .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles)
`ifdef OF_HAZARD_FWD_EN
        , .fwd1(fwd1), .fwd2(fwd2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        of_valid = 0; of_rs1 = 0; of_rs2 = 0; of_use1 = 0; of_use2 = 0;
        of_rd = 0; of_wr = 0; of_multi = 0; ex_ready = 1; flush = 0;
        wb_valid = 0; wb_rd = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 16'h0 || issue !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL reset_init busy=%h issue=%b stall=%b expected 0/0/0", busy, issue, stall);
        end
        tick();
        rst_n = 1'b1;
        tick();
        of_valid = 1; of_wr = 1; of_rd = 3;
        #1;
        checks++; if (issue !== 1'b1) begin
            errors++; $display("FAIL reset_build_issue got %b expected 1", issue);
        end
        tick();
        of_rd = 7; of_multi = 1;
        tick();
        of_rd = 3; of_multi = 0;
        #1;
        checks++; if (stall !== 1'b1) begin
            errors++; $display("FAIL reset_waw_stall got %b expected 1", stall);
        end
        tick();
        checks++; if (busy !== 16'h0088 || mdu_busy !== 1'b1 || stall_cycles !== 16'd1) begin
            errors++; $display("FAIL reset_pre busy=%h mdu=%b sc=%0d expected 0088/1/1", busy, mdu_busy, stall_cycles);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 16'h0 || mdu_busy !== 1'b0 || stall_cycles !== 16'd0) begin
            errors++; $display("FAIL reset_async busy=%h mdu=%b sc=%0d expected 0/0/0", busy, mdu_busy, stall_cycles);
        end
        idle();
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL reset_idle_out issue=%b stall=%b expected 0/0", issue, stall);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_raw();
        do_reset();
        of_valid = 1; of_wr = 1; of_rd = 3;
        tick();
        of_wr = 0; of_use1 = 1; of_rs1 = 3;
        #1;
        checks++; if (stall !== 1'b1 || issue !== 1'b0) begin
            errors++; $display("FAIL raw_stall stall=%b issue=%b expected 1/0", stall, issue);
        end
        tick();
        wb_valid = 1; wb_rd = 3;
        #1;
`ifdef OF_HAZARD_FWD_EN
        checks++; if (issue !== 1'b1 || fwd1 !== 1'b1) begin
            errors++; $display("FAIL raw_fwd issue=%b fwd1=%b expected 1/1", issue, fwd1);
        end
`else
        checks++; if (issue !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL raw_wb_bubble issue=%b stall=%b expected 0/1", issue, stall);
        end
`endif
        tick();
        wb_valid = 0;
        #1;
        checks++; if (issue !== 1'b1 || stall !== 1'b0 || busy !== 16'h0) begin
            errors++; $display("FAIL raw_after_wb issue=%b stall=%b busy=%h expected 1/0/0000", issue, stall, busy);
        end
        // r4 = r4 + 1 with r4 idle issues; same-cycle clear and set of r5 leaves r5 busy.
        idle();
        of_valid = 1; of_use1 = 1; of_rs1 = 4; of_wr = 1; of_rd = 4;
        #1;
        checks++; if (issue !== 1'b1) begin
            errors++; $display("FAIL self_dep issue=%b expected 1", issue);
        end
        tick();
        of_use1 = 0; of_rd = 5; wb_valid = 1; wb_rd = 5;
        tick();
        idle();
        #1;
        checks++; if (busy !== 16'h0030) begin
            errors++; $display("FAIL set_wins busy=%h expected 0030", busy);
        end
    endtask

    task automatic test_multi();
        do_reset();
        of_valid = 1; of_multi = 1;
        #1;
        checks++; if (issue !== 1'b1) begin
            errors++; $display("FAIL multi_first issue=%b expected 1", issue);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++; if (stall !== 1'b1 || issue !== 1'b0 || mdu_busy !== 1'b1) begin
                errors++; $display("FAIL multi_hold%0d stall=%b issue=%b mdu=%b expected 1/0/1", k, stall, issue, mdu_busy);
            end
            tick();
        end
        checks++; if (issue !== 1'b1 || mdu_busy !== 1'b0 || stall_cycles !== 16'd4) begin
            errors++; $display("FAIL multi_release issue=%b mdu=%b sc=%0d expected 1/0/4", issue, mdu_busy, stall_cycles);
        end
        idle();
    endtask

    task automatic test_ret();
        do_reset();
        of_valid = 1; of_wr = 1; of_rd = 15;
        tick();
        of_wr = 0; of_use1 = 1; of_rs1 = 15;
        tick();
        checks++; if (stall !== 1'b1 || issue !== 1'b0) begin
            errors++; $display("FAIL ret_stall stall=%b issue=%b expected 1/0", stall, issue);
        end
        of_rs1 = 2;
        #1;
        checks++; if (issue !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL ret_unrelated issue=%b stall=%b expected 1/0", issue, stall);
        end
        of_rs1 = 15; wb_valid = 1; wb_rd = 15;
        #1;
`ifdef OF_HAZARD_FWD_EN
        checks++; if (issue !== 1'b1 || fwd1 !== 1'b1) begin
            errors++; $display("FAIL ret_fwd issue=%b fwd1=%b expected 1/1", issue, fwd1);
        end
`else
        checks++; if (issue !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL ret_wb_bubble issue=%b stall=%b expected 0/1", issue, stall);
        end
`endif
        tick();
        wb_valid = 0;
        #1;
        checks++; if (issue !== 1'b1 || busy !== 16'h0) begin
            errors++; $display("FAIL ret_release issue=%b busy=%h expected 1/0000", issue, busy);
        end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        of_valid = 1; of_wr = 1; of_rd = 6;
        tick();
        of_wr = 0; of_use1 = 1; of_rs1 = 6; flush = 1;
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL flush_out issue=%b stall=%b expected 0/0", issue, stall);
        end
        tick();
        checks++; if (busy !== 16'h0040) begin
            errors++; $display("FAIL flush_busy busy=%h expected 0040", busy);
        end
        flush = 0; of_use1 = 0; of_wr = 1; of_rd = 9; ex_ready = 0;
        #1;
        checks++; if (stall !== 1'b1 || issue !== 1'b0) begin
            errors++; $display("FAIL notready stall=%b issue=%b expected 1/0", stall, issue);
        end
        tick();
        checks++; if (busy !== 16'h0040) begin
            errors++; $display("FAIL notready_busy busy=%h expected 0040", busy);
        end
        ex_ready = 1; of_rs1 = 6; of_rs2 = 6;
        #1;
        checks++; if (issue !== 1'b1) begin
            errors++; $display("FAIL unused_src issue=%b expected 1", issue);
        end
        of_valid = 0; of_use1 = 1; of_use2 = 1; of_wr = 0;
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL invalid_out issue=%b stall=%b expected 0/0", issue, stall);
        end
        idle();
        flush = 1; wb_valid = 1; wb_rd = 6;
        tick();
        idle();
        checks++; if (busy !== 16'h0) begin
            errors++; $display("FAIL flush_wb_clear busy=%h expected 0000", busy);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        of_valid = 1; ex_ready = 0;
        repeat (65534) tick();
        checks++; if (stall_cycles !== 16'hFFFE) begin
            errors++; $display("FAIL sat_pre sc=%h expected fffe", stall_cycles);
        end
        tick();
        checks++; if (stall_cycles !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hit sc=%h expected ffff", stall_cycles);
        end
        repeat (4465) tick();
        checks++; if (stall_cycles !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold sc=%h expected ffff", stall_cycles);
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_raw();
        test_multi();
        test_ret();
        test_flush();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/of_hazard_ctrl.md
Name: of_hazard_ctrl

Overview:
- Scoreboard-based issue controller sitting between the operand-fetch (OF) stage and execute (EX).
- Tracks which of the 16 architectural registers have a write in flight, including r15/ra used by ret.
- Decides each cycle whether the OF instruction issues to EX or holds OF/IF with a stall. Detects RAW, WAW and multi-cycle-unit structural hazards.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- NREG, 16, number of architectural registers (scoreboard width).
- RW, 4, register address width.
- MDU_LAT, 4, cycles the multi-cycle (mul/div/mod) unit is occupied after issue, range 1..15.
- SCNT_W, 16, stall counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- of_valid  in  1  OF holds a valid decoded instruction.
- of_rs1  in  RW  first source register (already 4'hF when isRet).
- of_rs2  in  RW  second source register (rd field when isSt).
- of_use1  in  1  instruction reads of_rs1.
- of_use2  in  1  instruction reads of_rs2.
- of_rd  in  RW  destination register.
- of_wr  in  1  instruction writes of_rd (call writes r15).
- of_multi  in  1  instruction uses the multi-cycle unit.
- ex_ready  in  1  EX can accept an instruction this cycle.
- flush  in  1  taken branch; OF instruction is squashed.
- wb_valid  in  1  writeback occurring this cycle.
- wb_rd  in  RW  writeback destination.
- issue  out  1  OF instruction transfers to EX this cycle.
- stall  out  1  hold IF and OF registers.
- busy  out  NREG  scoreboard bit vector.
- mdu_busy  out  1  multi-cycle unit occupied.
- stall_cycles  out  SCNT_W  saturating count of stalled cycles.

Behaviour:
- State:
  - busy[NREG-1:0], reset 0.
  - mdu_cnt[3:0], reset 0.
  - stall_cycles, reset 0.
- Reset is async on rst_n low and clears all state immediately. It is legal mid-operation; in-flight writebacks arriving after reset still perform their clear, which is a no-op.
- hazard = of_valid & ((of_use1 & busy[of_rs1]) | (of_use2 & busy[of_rs2]) | (of_wr & busy[of_rd]) | (of_multi & mdu_cnt!=0)).
- issue = of_valid & ~flush & ~hazard & ex_ready. This output is combinational, zero latency.
- stall = of_valid & ~flush & (hazard | ~ex_ready). This output is combinational.
- At reset, issue=0 and stall=0 unless of_valid is driven.
- Flush has priority over everything: no issue, no stall, scoreboard untouched. Already-issued instructions still write back and clear their bits.
- Scoreboard update per cycle:
  - Clear: if wb_valid, clear busy[wb_rd].
  - Set: if issue & of_wr, set busy[of_rd].
  - Same register set and clear in one cycle: set wins.
- mdu_cnt:
  - If issue & of_multi, load MDU_LAT.
  - Else if nonzero, decrement.
  - mdu_busy = (mdu_cnt != 0), registered-derived.
  - Back-to-back multi ops are spaced by MDU_LAT cycles.
- stall_cycles increments on every cycle stall=1 and saturates at all-ones with no wrap.
- Source and destination equal (e.g. r3 = r3 + 1): the RAW check uses the pre-update busy, so the instruction issues if r3 is idle.
- Unused sources (of_use*=0) never cause a hazard, even when the field decodes to a busy register.
- An X-free output is required when of_valid=0: issue=0, stall=0.

Optional Feature:
- Macro: OF_HAZARD_FWD_EN.
- When defined: a source match with wb_valid & wb_rd==rs in the same cycle is not a hazard, since the writeback value is bypassed. An additional output fwd1/fwd2 (1 bit each) is high when that bypass applies to rs1/rs2. WAW on that register is also resolved; set wins.
- When undefined: busy bits alone decide, giving a one-cycle bubble after writeback. fwd1/fwd2 are absent.

Test Plan:
- Reset with rst_n=0 mid-stream, having set busy=16'h0088 → busy=0, mdu_cnt=0, stall_cycles=0 asynchronously, before the next clk edge.
- Issue r3 write (of_wr=1, of_rd=3); next cycle OF reads rs1=3 → stall=1, issue=0. Apply wb_valid with wb_rd=3 → the following cycle issue=1. With OF_HAZARD_FWD_EN, issue=1 in the wb cycle and fwd1=1.
- Issue multi op (MDU_LAT=4), then another multi op → stall for 4 cycles, mdu_busy 1→0, issue on the 5th cycle; stall_cycles=4.
- Ret with rs1=15 while a call's r15 write is pending → stall until wb_rd=15; unrelated instruction using r2 issues without stall.
- Flush=1 while hazard is present → issue=0, stall=0, busy unchanged. Issue with ex_ready=0 → stall=1, no busy set.
- Hold stall for 70000 cycles (SCNT_W=16) → stall_cycles saturates at 16'hFFFF.
